// File: rtl/nios2_soc_mem_pkg.sv
// Shared constants and arbiter state encoding for the on-chip RAM arbiter.
package nios2_soc_mem_pkg;

  localparam int unsigned MEM_WORDS  = 5120;
  localparam int unsigned DefAddrW   = 13;
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefBeW     = DefDataW / 8;
  localparam int unsigned DefLockMax = 16;

  typedef logic [1:0] arb_state_e;
  localparam arb_state_e ARB  = 2'd0;
  localparam arb_state_e OWN0 = 2'd1;
  localparam arb_state_e OWN1 = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the side that did not win last goes.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/nios2_soc_onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port on-chip RAM, with round-robin
// fairness, bounded arbitration lock and fixed one-cycle read return.
module nios2_soc_onchip_mem_arbiter
  import nios2_soc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned BE_W     = DefBeW,
  parameter int unsigned LOCK_MAX = DefLockMax
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] av0_address,
  input  logic [BE_W-1:0]   av0_byteenable,
  input  logic              av0_read,
  input  logic              av0_write,
  input  logic              av0_lock,
  input  logic [DATA_W-1:0] av0_writedata,
  output logic              av0_waitrequest,
  output logic [DATA_W-1:0] av0_readdata,
  output logic              av0_readdatavalid,

  input  logic [ADDR_W-1:0] av1_address,
  input  logic [BE_W-1:0]   av1_byteenable,
  input  logic              av1_read,
  input  logic              av1_write,
  input  logic              av1_lock,
  input  logic [DATA_W-1:0] av1_writedata,
  output logic              av1_waitrequest,
  output logic [DATA_W-1:0] av1_readdata,
  output logic              av1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int unsigned     CntW    = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_MAX - 1);

  arb_state_e      state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]      rd_pend_q, rd_pend_d;

  logic [1:0] req, is_wr, arb_req, gnt, acc;
  logic       lk_sel, own_idx;

  // A write wins over a simultaneous read from the same master.
  assign req   = {av1_read | av1_write, av0_read | av0_write};
  assign is_wr = {av1_write, av0_write};

  always_comb begin
    unique case (state_q)
      OWN0:    arb_req = {1'b0, req[0]};
      OWN1:    arb_req = {req[1], 1'b0};
      default: arb_req = req;
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .req_i  (arb_req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign acc = gnt & {2{reset_n}};

  always_comb begin
    mem_chipselect = |acc;
    if (acc[1]) begin
      mem_write      = av1_write;
      mem_address    = av1_address;
      mem_byteenable = av1_byteenable;
      mem_writedata  = av1_writedata;
      lk_sel         = av1_lock;
    end else begin
      mem_write      = av0_write & acc[0];
      mem_address    = av0_address;
      mem_byteenable = av0_byteenable;
      mem_writedata  = av0_writedata;
      lk_sel         = av0_lock;
    end
  end

  assign own_idx = (state_q == OWN1);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (state_q == ARB) begin
      if (|acc) begin
        last_d = acc[1];
        if (lk_sel) begin
          state_d    = acc[1] ? OWN1 : OWN0;
          lock_cnt_d = '0;
        end
      end
    end else begin
      lock_cnt_d = lock_cnt_q + CntW'(1);
      if (acc[own_idx] && !lk_sel) begin
        state_d = ARB;
      end
      // Hold limit reached: force release and hand the next tie to the other master.
      if (lock_cnt_d == CntLast) begin
        state_d = ARB;
        last_d  = own_idx;
      end
    end
  end

  assign rd_pend_d = acc & ~is_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rd_pend_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign av0_waitrequest   = ~acc[0];
  assign av1_waitrequest   = ~acc[1];
  assign av0_readdatavalid = rd_pend_q[0];
  assign av1_readdatavalid = rd_pend_q[1];
  assign av0_readdata      = rd_pend_q[0] ? mem_readdata : '0;
  assign av1_readdata      = rd_pend_q[1] ? mem_readdata : '0;
  assign mem_clken         = reset_n;

endmodule

// File: tb/tb_nios2_soc_onchip_mem_arbiter.sv
// Bench for the on-chip RAM arbiter: RAM model, ownership/fairness reference model,
// directed scenarios and a randomized soak.
module tb_nios2_soc_onchip_mem_arbiter;

  localparam int unsigned AddrW   = 13;
  localparam int unsigned DataW   = 32;
  localparam int unsigned BeW     = 4;
  localparam int unsigned LockMax = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]       a_rd, a_wr, a_lk;
  logic [AddrW-1:0] a_addr [2];
  logic [BeW-1:0]   a_be   [2];
  logic [DataW-1:0] a_wd   [2];

  logic             av0_waitrequest, av1_waitrequest;
  logic             av0_readdatavalid, av1_readdatavalid;
  logic [DataW-1:0] av0_readdata, av1_readdata;
  logic [AddrW-1:0] mem_address;
  logic [BeW-1:0]   mem_byteenable;
  logic [DataW-1:0] mem_writedata, mem_readdata;
  logic             mem_chipselect, mem_write, mem_clken;

  nios2_soc_onchip_mem_arbiter #(
    .ADDR_W   (AddrW),
    .DATA_W   (DataW),
    .BE_W     (BeW),
    .LOCK_MAX (LockMax)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .av0_address       (a_addr[0]),
    .av0_byteenable    (a_be[0]),
    .av0_read          (a_rd[0]),
    .av0_write         (a_wr[0]),
    .av0_lock          (a_lk[0]),
    .av0_writedata     (a_wd[0]),
    .av0_waitrequest   (av0_waitrequest),
    .av0_readdata      (av0_readdata),
    .av0_readdatavalid (av0_readdatavalid),
    .av1_address       (a_addr[1]),
    .av1_byteenable    (a_be[1]),
    .av1_read          (a_rd[1]),
    .av1_write         (a_wr[1]),
    .av1_lock          (a_lk[1]),
    .av1_writedata     (a_wd[1]),
    .av1_waitrequest   (av1_waitrequest),
    .av1_readdata      (av1_readdata),
    .av1_readdatavalid (av1_readdatavalid),
    .mem_address       (mem_address),
    .mem_byteenable    (mem_byteenable),
    .mem_writedata     (mem_writedata),
    .mem_chipselect    (mem_chipselect),
    .mem_write         (mem_write),
    .mem_clken         (mem_clken),
    .mem_readdata      (mem_readdata)
  );

  // RAM: registered address, unregistered q, byte-lane writes; backdoor port for preload.
  logic [DataW-1:0] ram [0:8191];
  logic [AddrW-1:0] ram_addr_q;
  logic             bd_we;
  logic [AddrW-1:0] bd_addr;
  logic [DataW-1:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // Reference model: who owns the RAM, for how many cycles, who won last, expected returns.
  logic [DataW-1:0] shadow [0:8191];
  int               owner;
  int               held;
  int               last;
  bit               exp_rdv [2];
  logic [DataW-1:0] exp_rdd [2];

  int               n_checks;
  int               n_pass;
  int               obs_acc;
  logic             obs_rdv [2];
  logic [DataW-1:0] obs_rdd [2];
  int               rdv_pulses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit               req [2];
    bit               new_rdv [2];
    logic [DataW-1:0] new_rdd [2];
    int               g;
    int               o;
    @(negedge clk);
    obs_acc    = !av0_waitrequest ? 0 : (!av1_waitrequest ? 1 : -1);
    obs_rdv[0] = av0_readdatavalid;
    obs_rdv[1] = av1_readdatavalid;
    obs_rdd[0] = av0_readdata;
    obs_rdd[1] = av1_readdata;
    rdv_pulses += int'(av0_readdatavalid) + int'(av1_readdatavalid);
    new_rdv[0] = 1'b0;
    new_rdv[1] = 1'b0;
    new_rdd[0] = '0;
    new_rdd[1] = '0;
    if (!reset_n) begin
      check_eq("rst_wait0", 32'(av0_waitrequest), 1);
      check_eq("rst_wait1", 32'(av1_waitrequest), 1);
      check_eq("rst_rdv0", 32'(av0_readdatavalid), 0);
      check_eq("rst_rdv1", 32'(av1_readdatavalid), 0);
      check_eq("rst_rdd0", av0_readdata, 0);
      check_eq("rst_rdd1", av1_readdata, 0);
      check_eq("rst_cs", 32'(mem_chipselect), 0);
      check_eq("rst_we", 32'(mem_write), 0);
      check_eq("rst_clken", 32'(mem_clken), 0);
      owner = -1;
      held  = 0;
      last  = 1;
    end else begin
      check_eq("clken", 32'(mem_clken), 1);
      for (int n = 0; n < 2; n++) begin
        check_eq(n == 0 ? "rdv0" : "rdv1", 32'(n == 0 ? av0_readdatavalid : av1_readdatavalid),
                 32'(exp_rdv[n]));
        if (exp_rdv[n]) check_eq(n == 0 ? "rdd0" : "rdd1", obs_rdd[n], exp_rdd[n]);
        req[n] = a_rd[n] | a_wr[n];
      end
      g = -1;
      if (owner >= 0) begin
        if (req[owner]) g = owner;
      end else if (req[0] && req[1]) begin
        g = 1 - last;
      end else if (req[0]) begin
        g = 0;
      end else if (req[1]) begin
        g = 1;
      end
      check_eq("wait0", 32'(av0_waitrequest), 32'(g != 0));
      check_eq("wait1", 32'(av1_waitrequest), 32'(g != 1));
      check_eq("cs", 32'(mem_chipselect), 32'(g >= 0));
      check_eq("we", 32'(mem_write), 32'(g >= 0 && a_wr[g]));
      if (g >= 0) begin
        check_eq("maddr", 32'(mem_address), 32'(a_addr[g]));
        if (a_wr[g]) begin
          check_eq("mbe", 32'(mem_byteenable), 32'(a_be[g]));
          check_eq("mwd", mem_writedata, a_wd[g]);
          for (int b = 0; b < 4; b++) begin
            if (a_be[g][b]) shadow[a_addr[g]][b*8 +: 8] = a_wd[g][b*8 +: 8];
          end
        end else begin
          new_rdv[g] = 1'b1;
          new_rdd[g] = shadow[a_addr[g]];
        end
      end
      if (owner < 0) begin
        if (g >= 0) begin
          last = g;
          if (a_lk[g]) begin
            owner = g;
            held  = 1;
          end
        end
      end else begin
        o = owner;
        held++;
        if ((g == o && !a_lk[o]) || held >= LockMax) owner = -1;
        if (held >= LockMax) last = o;
      end
    end
    exp_rdv = new_rdv;
    exp_rdd = new_rdd;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input bit rd, input bit wr, input bit lk,
                       input logic [AddrW-1:0] addr, input logic [BeW-1:0] be,
                       input logic [DataW-1:0] wd);
    a_rd[n]   = rd;
    a_wr[n]   = wr;
    a_lk[n]   = lk;
    a_addr[n] = addr;
    a_be[n]   = be;
    a_wd[n]   = wd;
  endtask

  task automatic idle();
    a_rd = '0;
    a_wr = '0;
    a_lk = '0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic bd_write(input logic [AddrW-1:0] addr, input logic [DataW-1:0] data);
    bd_we        = 1'b1;
    bd_addr      = addr;
    bd_data      = data;
    shadow[addr] = data;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rdv_pulses = 0;
    owner      = -1;
    held       = 0;
    last       = 1;
    for (int n = 0; n < 2; n++) begin
      exp_rdv[n] = 1'b0;
      exp_rdd[n] = '0;
      drive(n, 0, 0, 0, '0, '0, '0);
    end
    reset_n = 1'b0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    for (int i = 0; i < 64; i++) bd_write(AddrW'(i), $urandom);
    bd_write(13'h0010, 32'hDEADBEEF);
    bd_write(13'h1000, 32'hFFFFFFFF);

    apply_reset();

    // Single uncontended read.
    drive(0, 1, 0, 0, 13'h0010, 4'hF, '0);
    step();
    check_eq("rd1_acc", obs_acc, 0);
    idle();
    step();
    check_eq("rd1_rdv0", 32'(obs_rdv[0]), 1);
    check_eq("rd1_data", obs_rdd[0], 32'hDEADBEEF);
    check_eq("rd1_rdv1", 32'(obs_rdv[1]), 0);

    // Continuous contention from reset alternates strictly.
    apply_reset();
    rdv_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, AddrW'(i), 4'hF, '0);
      drive(1, 1, 0, 0, AddrW'(32 + i), 4'hF, '0);
      step();
      check_eq("rr_order", obs_acc, i % 2);
    end
    idle();
    step();
    check_eq("rr_rdv_count", rdv_pulses, 8);

    // Partial byte write followed by read of the same word.
    drive(1, 0, 1, 0, 13'h1000, 4'b0101, 32'h11223344);
    step();
    drive(1, 1, 0, 0, 13'h1000, 4'hF, '0);
    step();
    idle();
    step();
    check_eq("bw_rdv1", 32'(obs_rdv[1]), 1);
    check_eq("bw_data", obs_rdd[1], 32'hFF22FF44);

    // Locked burst from master 0 starves master 1 until the unlocked write.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, i < 3, AddrW'(40 + i), 4'hF, $urandom);
      drive(1, 1, 0, 0, 13'h0005, 4'hF, '0);
      step();
      check_eq("lock_acc", obs_acc, 0);
    end
    drive(0, 0, 0, 0, '0, '0, '0);
    step();
    check_eq("lock_rel", obs_acc, 1);
    idle();
    step();

    // Lock held by an idle master times out after LockMax cycles.
    apply_reset();
    drive(0, 0, 1, 1, 13'h0021, 4'hF, $urandom);
    drive(1, 1, 0, 0, 13'h0006, 4'hF, '0);
    step();
    check_eq("to_lock", obs_acc, 0);
    drive(0, 0, 0, 0, '0, '0, '0);
    for (int k = 1; k < int'(LockMax); k++) begin
      step();
      check_eq("to_hold", obs_acc, -1);
    end
    drive(0, 1, 0, 0, 13'h0007, 4'hF, '0);
    step();
    check_eq("to_tie", obs_acc, 1);
    idle();
    step();

    // Reset right after an accepted read drops the return.
    drive(0, 1, 0, 0, 13'h0010, 4'hF, '0);
    step();
    check_eq("rr_acc", obs_acc, 0);
    reset_n = 1'b0;
    drive(1, 1, 0, 0, 13'h0011, 4'hF, '0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("rst_tie", obs_acc, 0);
    check_eq("rst_nordv", 32'(obs_rdv[0]), 0);
    idle();
    step();

    // Randomized soak against the reference model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(0, 9) < 6) begin
          drive(n, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) == 0, AddrW'($urandom_range(0, 63)),
                BeW'($urandom), $urandom);
          if (!a_rd[n] && !a_wr[n]) a_rd[n] = 1'b1;
        end else begin
          drive(n, 0, 0, 0, a_addr[n], a_be[n], a_wd[n]);
        end
      end
      step();
    end
    reset_n = 1'b1;
    idle();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nios2_soc_onchip_mem_arbiter.md
# nios2_soc_onchip_mem_arbiter

Two-requester Avalon-MM arbiter that shares the single-port on-chip RAM (13-bit word address, 32-bit data, 4 byte lanes, 5120 words, address registered inside the RAM, unregistered output) between two masters, e.g. the Nios II data master and a DMA. It sits between the interconnect and the RAM instance. It provides round-robin fairness, Avalon arbitration lock with a bounded hold time, fixed one-cycle read latency with `readdatavalid`, and back-to-back throughput of one transfer per cycle.

## Interface
- `ADDR_W`, 13, word address width (RAM depth 5120 ≤ 2^13)
- `DATA_W`, 32, data width
- `BE_W`, 4, byte-enable width (`DATA_W/8`)
- `LOCK_MAX`, 16, maximum consecutive cycles one requester may own the RAM under lock (≥ 2)

- `clk`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous assert, active-low; deassertion synchronised externally
- `avN_address`  in  ADDR_W  requester N (N = 0, 1) word address
- `avN_byteenable`  in  BE_W  requester N byte lanes (write only; reads return all lanes)
- `avN_read` / `avN_write`  in  1  requester N command
- `avN_lock`  in  1  requester N arbitration lock, sampled with its command
- `avN_writedata`  in  DATA_W  requester N write data
- `avN_waitrequest`  out  1  low exactly in the cycle requester N's command is accepted
- `avN_readdata`  out  DATA_W  read data, valid with `avN_readdatavalid`
- `avN_readdatavalid`  out  1  one-cycle pulse, one per accepted read
- `mem_address`, `mem_byteenable`, `mem_writedata`  out  ADDR_W/BE_W/DATA_W  to RAM
- `mem_chipselect`, `mem_write`  out  1  to RAM; `mem_clken` out 1, constant 1 outside reset
- `mem_readdata`  in  DATA_W  RAM `q`, valid the cycle after the address is presented

## Operation
- Request N = `avN_read | avN_write`. If both are set, treat it as a write; the read is ignored, not queued.
- FSM states: `ARB`, `OWN0`, `OWN1`. Reset state is `ARB`, with `last` = 1 so that requester 0 wins the first tie.
- In `ARB`:
  - A single requester is granted.
  - If both request, grant `~last`.
  - Update `last` to the granted index.
  - If the granted command has `lock` = 1, go to `OWNn` and clear `lock_cnt` to 0.
- In `OWNn`:
  - Only requester n can be granted. The other requester waits even if n is idle.
  - `lock_cnt` increments every cycle.
  - An accepted command from n with `lock` = 0 returns to `ARB`.
  - When `lock_cnt` = `LOCK_MAX-1`, return to `ARB` unconditionally and set `last` = n, so the other requester wins the next tie.
- Accept means the granted requester has a request this cycle:
  - Drive `mem_chipselect` = 1, `mem_write` = the write flag, and its address, byteenable and writedata, all combinationally.
  - Drop that requester's `waitrequest`.
  - Hold all non-accepted requesters' `waitrequest` at 1.
- With no accept: `mem_chipselect` = 0 and `mem_write` = 0. Address and data hold their last value (don't-care).
- Read return:
  - Register `rd_pend[N]` on an accepted read.
  - Next cycle: `avN_readdatavalid` = 1 and `avN_readdata` = `mem_readdata`.
  - Reads pipeline, so a new accept can occur in the same cycle data returns.
- Read-after-write to the same address in consecutive cycles returns the new data. Byte lanes not enabled in the write keep their old values.

## Timing
- Grant and `waitrequest` are combinational from the requests and registered state. Cycle from request to accept: 0 cycles when uncontended.
- Read latency: `readdatavalid` arrives exactly 1 cycle after the accept cycle. There is no variable latency.
- Throughput: 1 transfer per cycle total. With both requesters continuously busy and unlocked, accepts strictly alternate 0, 1, 0, 1, …
- Reset (`reset_n` = 0, any cycle, including mid-read or mid-lock):
  - All `waitrequest` = 1, `readdatavalid` = 0, `readdata` = 0.
  - `mem_chipselect` = 0, `mem_write` = 0, `mem_clken` = 0.
  - State returns to `ARB`, `last` = 1, `lock_cnt` = 0, `rd_pend` = 0.
  - Pending reads are dropped with no `readdatavalid`.
- A lock timeout and an unlocked accept in the same cycle both lead to `ARB`. The timeout's `last` = n rule applies.

## Structure
- A shared package `nios2_soc_mem_pkg` holds:
  - the FSM state enum (`ARB`, `OWN0`, `OWN1`)
  - `MEM_WORDS` = 5120
  - default widths
- One natural sub-module: `rr_arb2`, a combinational two-way round-robin pick from (`req[1:0]`, `last`) → `gnt[1:0]`.
- Everything else stays in the top module.

## Test plan
- **Single read:** preload word 0x0010 = 0xDEADBEEF; `av0_read` at address 0x0010 → `av0_waitrequest` = 0 the same cycle, `av0_readdatavalid` = 1 with 0xDEADBEEF the next cycle, `av1` untouched.
- **Contention:** both requesters read every cycle for 8 cycles from reset → accepts in order 0, 1, 0, 1, 0, 1, 0, 1; 8 `readdatavalid` pulses, each routed to the correct requester one cycle after its accept.
- **Byte write then read:** `av1` writes 0x11223344 with byteenable 0b0101 over 0xFFFFFFFF at address 0x1000, then reads it the next cycle → returns 0xFF22FF44.
- **Lock:** `av0` issues 3 locked writes plus 1 unlocked write while `av1` requests continuously → `av1` waits 4 cycles, then is granted in cycle 5.
- **Lock timeout:** `av0` locks then goes idle while `av1` requests, with `LOCK_MAX` = 16 → `av1` is accepted exactly 16 cycles after `av0`'s locked accept; next tie goes to 1.
- **Reset mid-read:** assert `reset_n` low in the cycle after an accepted read → no `readdatavalid`; all outputs at reset values; after release the first tie is granted to requester 0.
